mat_stream_2_axi_stream_packer: RTL

Packs an 8-bit pixel stream from the image pipeline back into 64-bit words for the AXI-stream output path. It reads `rows` and `cols` descriptors from FIFOs, then consumes exactly rows×cols pixels. Pixels are packed eight per word, with the first pixel in the least significant byte, and each word is written to the output word FIFO. It sits at the tail of the pp_pipeline_accel dataflow region, between the last Mat stream and the AXI-stream writer.

---
 rtl/mat2axi_pkg.sv | 17 +
 rtl/mat2axi_mul_32u_2stage.sv | 30 +++
 rtl/mat_stream_2_axi_stream_packer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mat2axi_pkg.sv
// Shared types and sizing for the Mat-stream to AXI-stream word packer.
package mat2axi_pkg;

    localparam int PIX_W     = 8;
    localparam int WORD_W    = 64;
    localparam int LANES     = WORD_W / PIX_W;
    localparam int LANE_BITS = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_MUL2 = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } mat2axi_state_t;

endpackage

// File: rtl/mat2axi_mul_32u_2stage.sv
// Unsigned 32x32 multiplier keeping the low 32 bits, two register stages.
// The first stage doubles as the descriptor capture: operands presented in
// the accept cycle yield the product two cycles later.
module mat2axi_mul_32u_2stage (
    input  logic        clk,
    input  logic        ce,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic [31:0] a_r;
    logic [31:0] b_r;

    // Stage 1: register operands
    always_ff @(posedge clk) begin
        if (ce) begin
            a_r <= a;
            b_r <= b;
        end
    end

    // Stage 2: low half of the product, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (ce) begin
            p <= a_r * b_r;
        end
    end

endmodule

// File: rtl/mat_stream_2_axi_stream_packer.sv
// Packs a pixel stream into words, first pixel in the least significant lane.
// Each frame is sized by a rows/cols descriptor pair; a short final word is
// zero-padded in its upper lanes and the lane index restarts every frame.
module mat_stream_2_axi_stream_packer #(
    parameter int PIX_W  = mat2axi_pkg::PIX_W,
    parameter int WORD_W = mat2axi_pkg::WORD_W,
    parameter int LANES  = WORD_W / PIX_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [PIX_W-1:0]  img_dout,
    input  logic              img_empty_n,
    output logic              img_read,
    output logic [WORD_W-1:0] ldata_din,
    input  logic              ldata_full_n,
    output logic              ldata_write,
    input  logic [31:0]       rows_dout,
    input  logic              rows_empty_n,
    output logic              rows_read,
    input  logic [31:0]       cols_dout,
    input  logic              cols_empty_n,
    output logic              cols_read
);
    import mat2axi_pkg::*;

    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    mat2axi_state_t state;
    mat2axi_state_t state_next;

    logic [LANES-1:0][PIX_W-1:0] acc;
    logic [LANES-1:0][PIX_W-1:0] acc_ins;
    logic [LANE_IDX_W-1:0]       lane;
    logic [31:0]                 remaining;
    logic [31:0]                 total;
    logic                        done_reg;
    logic                        done_pulse;
    logic                        last;
    logic                        pop;

    // rows*cols: operands sampled straight off the descriptor FIFOs in the
    // accept cycle, product valid while in MUL2
    mat2axi_mul_32u_2stage u_mul (
        .clk (ap_clk),
        .ce  (1'b1),
        .a   (rows_dout),
        .b   (cols_dout),
        .p   (total)
    );

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and FIFO handshakes; a pixel that completes a word is only
    // taken when the word FIFO can accept the word in the same cycle
    always_comb begin
        state_next  = state;
        rows_read   = 1'b0;
        cols_read   = 1'b0;
        img_read    = 1'b0;
        ldata_write = 1'b0;
        ap_ready    = 1'b0;
        done_pulse  = 1'b0;
        pop         = 1'b0;
        last        = (lane == LANE_IDX_W'(LANES - 1)) | (remaining == 32'd1);
        case (state)
            S_IDLE: begin
                if (ap_start & rows_empty_n & cols_empty_n & !done_reg) begin
                    rows_read  = 1'b1;
                    cols_read  = 1'b1;
                    state_next = S_MUL1;
                end
            end
            S_MUL1: state_next = S_MUL2;
            S_MUL2: state_next = (total == 32'd0) ? S_DONE : S_RUN;
            S_RUN: begin
                pop         = img_empty_n & (!last | ldata_full_n);
                img_read    = pop;
                ldata_write = pop & last;
                if (pop && (remaining == 32'd1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                ap_ready   = 1'b1;
                done_pulse = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outgoing word: accumulator with the current pixel dropped into its lane;
    // lanes above are still zero from the last clear
    always_comb begin
        acc_ins       = acc;
        acc_ins[lane] = img_dout;
        ldata_din     = ldata_write ? acc_ins : '0;
    end

    assign ap_done = done_pulse | done_reg;
    assign ap_idle = (state == S_IDLE) & !ap_start;

    // Lane, remaining-pixel count and partial-word accumulator
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            lane      <= '0;
            acc       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_MUL2: begin
                    remaining <= total;
                    lane      <= '0;
                    acc       <= '0;
                end
                S_RUN: begin
                    if (pop) begin
                        remaining <= remaining - 32'd1;
                        if (last) begin
                            lane <= '0;
                            acc  <= '0;
                        end else begin
                            lane      <= lane + LANE_IDX_W'(1);
                            acc[lane] <= img_dout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Held done: continue wins over a set in the same cycle
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            done_reg <= 1'b0;
        end else if (ap_continue) begin
            done_reg <= 1'b0;
        end else if (state == S_DONE) begin
            done_reg <= 1'b1;
        end
    end

endmodule
